// File: rtl/cog_pkg.sv
// Shared definitions for the cog pin conditioning logic: wait-engine state
// encoding, pin bus width and the masked pin-compare helper.
package cog_pkg;

    localparam int PIN_COUNT = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } wait_state_e;

    // pne=0 completes on equality, pne=1 on inequality
    function automatic logic pin_match(
        input logic [PIN_COUNT-1:0] pins,
        input logic [PIN_COUNT-1:0] mask,
        input logic [PIN_COUNT-1:0] value,
        input logic                 pne
    );
        logic eq;
        eq = ((pins & mask) == value);
        return pne ? !eq : eq;
    endfunction

endpackage

// File: rtl/pin_filter_bit.sv
// Single-pin glitch filter: the output follows the input only after the input
// has disagreed with it for FILT_LEN consecutive samples.
module pin_filter_bit #(
    parameter int FILT_LEN = 3
) (
    input  logic clk_cog,
    input  logic nres,
    input  logic sample,
    output logic level
);

    localparam logic [3:0] CNT_LIMIT = 4'(FILT_LEN - 1);

    logic [3:0] cnt_q;
    logic       level_q;

    always_ff @(posedge clk_cog) begin
        if (!nres) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else if (sample != level_q) begin
            if (cnt_q == CNT_LIMIT) begin
                level_q <= sample;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 4'd1;
            end
        end else begin
            // any agreeing sample restarts the qualification window
            cnt_q <= '0;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/cog_pin_sync.sv
// Pin input conditioning for the cog counters: synchroniser, optional glitch
// filter (PIN_GLITCH_FILTER_EN), edge pulses and the WAITPEQ/WAITPNE engine.
module cog_pin_sync
    import cog_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic                 clk_cog,
    input  logic                 nres,
    input  logic [PIN_COUNT-1:0] pin_raw,
    output logic [PIN_COUNT-1:0] pin_in,
    output logic [PIN_COUNT-1:0] pin_rise,
    output logic [PIN_COUNT-1:0] pin_fall,
    input  logic                 wait_req,
    input  logic                 wait_pne,
    input  logic [PIN_COUNT-1:0] wait_mask,
    input  logic [PIN_COUNT-1:0] wait_value,
    input  logic                 wait_abort,
    output logic                 wait_busy,
    output logic                 wait_done,
    output logic [31:0]          wait_cycles
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("cog_pin_sync: SYNC_STAGES must be 2..4");
    end
    if (FILT_LEN < 2 || FILT_LEN > 15) begin : g_bad_filt
        $error("cog_pin_sync: FILT_LEN must be 2..15");
    end

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    // ---- stage p0: synchroniser chain, element 0 samples the raw pins ----
    logic [SYNC_STAGES-1:0][PIN_COUNT-1:0] sync_p0;
    logic [PIN_COUNT-1:0]                  pin_in_p1;

    always_ff @(posedge clk_cog) begin
        if (!nres) begin
            sync_p0 <= '0;
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], pin_raw};
        end
    end

    // ---- stage p1: conditioned pin level ----
`ifdef PIN_GLITCH_FILTER_EN
    for (genvar g = 0; g < PIN_COUNT; g++) begin : g_filt
        pin_filter_bit #(
            .FILT_LEN (FILT_LEN)
        ) u_filt (
            .clk_cog (clk_cog),
            .nres    (nres),
            .sample  (sync_p0[SYNC_STAGES-1][g]),
            .level   (pin_in_p1[g])
        );
    end
`else
    assign pin_in_p1 = sync_p0[SYNC_STAGES-1];
`endif

    assign pin_in = pin_in_p1;

    // ---- stage p2: registered edge pulses ----
    logic [PIN_COUNT-1:0] prev_p2;
    logic [PIN_COUNT-1:0] rise_p2;
    logic [PIN_COUNT-1:0] fall_p2;

    always_ff @(posedge clk_cog) begin
        if (!nres) begin
            prev_p2 <= '0;
            rise_p2 <= '0;
            fall_p2 <= '0;
        end else begin
            prev_p2 <= pin_in_p1;
            rise_p2 <= pin_in_p1 & ~prev_p2;
            fall_p2 <= ~pin_in_p1 & prev_p2;
        end
    end

    assign pin_rise = rise_p2;
    assign pin_fall = fall_p2;

    // ---- wait engine ----
    wait_state_e          state_q, state_d;
    logic                 pne_q;
    logic [PIN_COUNT-1:0] mask_q;
    logic [PIN_COUNT-1:0] value_q;
    logic [31:0]          cycles_q;
    logic                 start;
    logic                 count;

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        count   = 1'b0;
        case (state_q)
            IDLE: begin
                if (wait_req && !wait_abort) begin
                    state_d = WAIT;
                    start   = 1'b1;
                end
            end
            WAIT: begin
                // abort outranks a match seen on the same edge
                if (wait_abort) begin
                    state_d = IDLE;
                end else if (pin_match(pin_in_p1, mask_q, value_q, pne_q)) begin
                    state_d = DONE;
                end else begin
                    count = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_cog) begin
        if (!nres) begin
            state_q  <= IDLE;
            pne_q    <= 1'b0;
            mask_q   <= '0;
            value_q  <= '0;
            cycles_q <= '0;
        end else begin
            state_q <= state_d;
            if (start) begin
                pne_q    <= wait_pne;
                mask_q   <= wait_mask;
                value_q  <= wait_value;
                cycles_q <= '0;
            end else if (count) begin
                cycles_q <= sat_inc(cycles_q);
            end
        end
    end

    assign wait_busy   = (state_q == WAIT);
    assign wait_done   = (state_q == DONE);
    assign wait_cycles = cycles_q;

endmodule
